// File: rtl/sdram_timer_bank_if.sv
// Control/status bundle between the SDRAM controller FSM and the timer bank.
// The controller side uses the master modport and the timer bank uses the slave modport.
interface sdram_timer_bank_if #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned SELW = 2
);
  logic [NCH-1:0]           reload;
  logic [NCH-1:0][SELW-1:0] sel;
  logic [NCH-1:0]           periodic;
  logic [NCH-1:0]           cancel;
  logic [NCH-1:0]           ready;
  logic [NCH-1:0]           expire;
  logic                     all_ready;

  modport master (
    output reload, sel, periodic, cancel,
    input  ready, expire, all_ready
  );

  modport slave (
    input  reload, sel, periodic, cancel,
    output ready, expire, all_ready
  );
endinterface

// File: rtl/sdram_timer_bank.sv
// Bank of independent SDRAM timing-constraint counters with merge, periodic reload and cancel.
// A channel reports ready once its pending constraint has counted down to zero.
module sdram_timer_bank #(
  parameter int unsigned               NCH     = 4,
  parameter int unsigned               N       = 8,
  parameter int unsigned               NSEL    = 4,
  parameter logic [NSEL-1:0][N-1:0]    PERIODS = {8'd8, 8'd4, 8'd3, 8'd1}
) (
  input logic               clk,
  input logic               n_reset,
  sdram_timer_bank_if.slave bus
);

  localparam int unsigned SelW = (NSEL > 1) ? $clog2(NSEL) : 1;

  if (NSEL < 1 || N < 2) begin : g_bad_params
    $error("sdram_timer_bank: NSEL must be >= 1 and N >= 2");
  end

  logic [NCH-1:0][N-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][N-1:0] per_q, per_d;
  logic [NCH-1:0]        mode_q, mode_d;
  logic [NCH-1:0]        exp_q, exp_d;
  logic [NCH-1:0]        ready;

  function automatic logic [N-1:0] period_of(input logic [SelW-1:0] s);
    if (32'(s) < NSEL) return PERIODS[s];
    return '0;
  endfunction

  // Periodic mode needs at least two cycles per period to produce a visible expire.
  function automatic logic [N-1:0] eff_period(input logic [SelW-1:0] s, input logic per);
    logic [N-1:0] p;
    p = period_of(s);
    if (per && (p < N'(2))) return N'(2);
    return p;
  endfunction

  function automatic logic [N-1:0] sat_dec(input logic [N-1:0] x);
    return (x == '0) ? '0 : x - N'(1);
  endfunction

  function automatic logic [N-1:0] max_n(input logic [N-1:0] a, input logic [N-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    cnt_d  = cnt_q;
    per_d  = per_q;
    mode_d = mode_q;
    exp_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.cancel[i]) begin
        cnt_d[i]  = '0;
        mode_d[i] = 1'b0;
      end else begin
        if (bus.reload[i]) begin
          per_d[i]  = eff_period(bus.sel[i], bus.periodic[i]);
          mode_d[i] = bus.periodic[i];
          // A new constraint may extend but never shorten a pending one.
          cnt_d[i]  = max_n(sat_dec(cnt_q[i]), sat_dec(per_d[i]));
        end else if (mode_q[i] && exp_q[i]) begin
          cnt_d[i] = sat_dec(per_q[i]);
        end else begin
          cnt_d[i] = sat_dec(cnt_q[i]);
        end
        exp_d[i] = (cnt_q[i] == N'(1)) && (cnt_d[i] == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q  <= '0;
      per_q  <= '0;
      mode_q <= '0;
      exp_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      mode_q <= mode_d;
      exp_q  <= exp_d;
    end
  end

  always_comb begin
    ready = '0;
    for (int i = 0; i < NCH; i++) begin
      ready[i] = (cnt_q[i] == '0);
    end
  end

  assign bus.ready     = ready;
  assign bus.expire    = exp_q;
  assign bus.all_ready = &ready;

endmodule

// File: tb/tb_sdram_timer_bank.sv
// Self-checking bench for sdram_timer_bank: table-driven cycle vectors through a scoreboard queue,
// plus a hand-written asynchronous reset sequence.
module tb_sdram_timer_bank;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  sdram_timer_bank_if #(.NCH(4), .SELW(2)) bus ();

  sdram_timer_bank dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0] reload;
    logic [7:0] sel;
    logic [3:0] periodic;
    logic [3:0] cancel;
    logic [3:0] r;
    logic [3:0] e;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] r;
    logic [3:0] e;
    logic       a;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  function automatic void add(input logic [3:0] rl, input logic [7:0] sl, input logic [3:0] pr,
                              input logic [3:0] cn, input logic [3:0] r, input logic [3:0] e);
    vec_t v;
    v.reload = rl; v.sel = sl; v.periodic = pr; v.cancel = cn; v.r = r; v.e = e;
    vecs.push_back(v);
  endfunction

  function automatic void idle(input int n, input logic [3:0] r, input logic [3:0] e);
    for (int k = 0; k < n; k++) add(4'h0, 8'h00, 4'h0, 4'h0, r, e);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) $display("FAIL %s row %0d: got %b want %b", nm, idx, got, want);
    else passed++;
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
  task automatic step(input int idx, input vec_t v);
    exp_t x, y;
    bus.reload = v.reload; bus.sel = v.sel; bus.periodic = v.periodic; bus.cancel = v.cancel;
    x.idx = idx; x.r = v.r; x.e = v.e; x.a = &v.r;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL scoreboard row %0d: got empty queue want entry", idx);
    end else begin
      y = sb.pop_front();
      chk("ready", y.idx, bus.ready, y.r);
      chk("expire", y.idx, bus.expire, y.e);
      chk("all_ready", y.idx, {3'b0, bus.all_ready}, {3'b0, y.a});
    end
  endtask

  task automatic async_reset_check(input string nm);
    chk({nm, "_ready"}, -1, bus.ready, 4'hF);
    chk({nm, "_expire"}, -1, bus.expire, 4'h0);
    chk({nm, "_all_ready"}, -1, {3'b0, bus.all_ready}, 4'h1);
  endtask

  initial begin
    vec_t v;
    bus.reload = '0; bus.sel = '0; bus.periodic = '0; bus.cancel = '0;

    // One-shot ch0, P=4.
    add(4'h1, 8'h02, 4'h0, 4'h0, 4'b1110, 4'h0);
    idle(2, 4'b1110, 4'h0);
    idle(1, 4'hF, 4'b0001);
    idle(1, 4'hF, 4'h0);
    // Merge ch1: P=8 then P=3 two cycles later.
    add(4'h2, 8'h0C, 4'h0, 4'h0, 4'b1101, 4'h0);
    idle(1, 4'b1101, 4'h0);
    add(4'h2, 8'h04, 4'h0, 4'h0, 4'b1101, 4'h0);
    idle(4, 4'b1101, 4'h0);
    idle(1, 4'hF, 4'b0010);
    idle(1, 4'hF, 4'h0);
    // Merge ch1: P=3 then P=8 one cycle later.
    add(4'h2, 8'h04, 4'h0, 4'h0, 4'b1101, 4'h0);
    add(4'h2, 8'h0C, 4'h0, 4'h0, 4'b1101, 4'h0);
    idle(6, 4'b1101, 4'h0);
    idle(1, 4'hF, 4'b0010);
    idle(1, 4'hF, 4'h0);
    // Periodic ch2, P=3, cancelled after second expire.
    add(4'h4, 8'h10, 4'h4, 4'h0, 4'b1011, 4'h0);
    idle(1, 4'b1011, 4'h0);
    idle(1, 4'hF, 4'b0100);
    idle(2, 4'b1011, 4'h0);
    idle(1, 4'hF, 4'b0100);
    idle(1, 4'b1011, 4'h0);
    add(4'h0, 8'h00, 4'h0, 4'h4, 4'hF, 4'h0);
    idle(3, 4'hF, 4'h0);
    // P=1 one-shot on ch3: no stall, no expire.
    add(4'h8, 8'h00, 4'h0, 4'h0, 4'hF, 4'h0);
    idle(1, 4'hF, 4'h0);
    // P=1 periodic on ch3: clamped to 2, cancel in an expire cycle.
    add(4'h8, 8'h00, 4'h8, 4'h0, 4'b0111, 4'h0);
    idle(1, 4'hF, 4'b1000);
    idle(1, 4'b0111, 4'h0);
    idle(1, 4'hF, 4'b1000);
    add(4'h0, 8'h00, 4'h0, 4'h8, 4'hF, 4'h0);
    idle(1, 4'hF, 4'h0);
    // Cancel and reload together on ch0: cancel wins.
    add(4'h1, 8'h02, 4'h0, 4'h1, 4'hF, 4'h0);
    idle(1, 4'hF, 4'h0);
    // Periodic ch2 P=3, reloaded with P=8 in its expire cycle.
    add(4'h4, 8'h10, 4'h4, 4'h0, 4'b1011, 4'h0);
    idle(1, 4'b1011, 4'h0);
    idle(1, 4'hF, 4'b0100);
    add(4'h4, 8'h30, 4'h4, 4'h0, 4'b1011, 4'h0);
    idle(6, 4'b1011, 4'h0);
    idle(1, 4'hF, 4'b0100);
    add(4'h0, 8'h00, 4'h0, 4'h4, 4'hF, 4'h0);
    idle(1, 4'hF, 4'h0);
    // All channels at once: ch0 P=8, ch1 P=4, ch2 P=3, ch3 P=1.
    add(4'hF, 8'h1B, 4'h0, 4'h0, 4'b1000, 4'h0);
    idle(1, 4'b1000, 4'h0);
    idle(1, 4'b1100, 4'b0100);
    idle(1, 4'b1110, 4'b0010);
    idle(3, 4'b1110, 4'h0);
    idle(1, 4'hF, 4'b0001);
    idle(1, 4'hF, 4'h0);

    #12;
    async_reset_check("reset_init");
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) step(i, vecs[i]);

    // Asynchronous reset in the middle of a periodic countdown on ch2.
    v.reload = 4'h4; v.sel = 8'h30; v.periodic = 4'h4; v.cancel = 4'h0;
    v.r = 4'b1011; v.e = 4'h0;
    step(1000, v);
    v.reload = 4'h0; v.sel = 8'h00; v.periodic = 4'h0;
    step(1001, v);
    step(1002, v);
    #2;
    n_reset = 1'b0;
    #1;
    async_reset_check("reset_mid");
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    v.r = 4'hF; v.e = 4'h0;
    for (int i = 0; i < 12; i++) step(1100 + i, v);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
